filter_pulse_meas: RTL and testbench
====================================

Name: filter_pulse_meas

Overview:
- Downstream consumer of the glitch filter's filtered output (data_out).
- Measures the duration, in clock cycles, of each high and low phase of the filtered signal.
- Pushes each {level, duration} record into a small synchronous FIFO for software or DMA readout.
- Raises a level interrupt when records are pending or when data was lost to overflow.

Parameters:
- CNT_W, 16, width of the duration counter and of the record duration field.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of 2 and at least 2.
- ADDR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, not overridable.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- data_i  in  1  filtered input, driven by the filter's data_out; synchronous to clk_i
- meas_en_i  in  1  measurement enable
- edge_sel_i  in  2  phase select: 00 both, 01 high phases only, 10 low phases only, 11 treated as 00
- irq_en_i  in  1  interrupt enable
- rd_req_i  in  1  pop request for the FIFO head
- clr_ovf_i  in  1  clears the sticky overflow flag
- rd_data_o  out  CNT_W+1  FIFO head: bit [CNT_W] = level of the ended phase, bits [CNT_W-1:0] = duration
- fifo_empty_o  out  1  FIFO empty
- fifo_full_o  out  1  FIFO full
- fifo_level_o  out  ADDR_W+1  number of stored records
- ovf_o  out  1  sticky overflow flag
- irq_o  out  1  level interrupt

Behaviour:
- Reset values:
  - fifo_empty_o=1, fifo_full_o=0, fifo_level_o=0, ovf_o=0, irq_o=0, rd_data_o=0.
  - Internally: data_d=0, counter=0, state=IDLE.
- Edge detection: data_d is data_i registered every cycle. An edge is present in any cycle where data_i != data_d.
- State machine:
  - IDLE: counter held at 0, no pushes. Goes to ARM when meas_en_i=1.
  - ARM: waits for the first edge; nothing is pushed because the phase before it is partial. On that edge, counter<=1 and the state goes to MEAS.
  - MEAS, no edge: counter<=counter+1, saturating at all-ones (no wrap).
  - MEAS, edge: a record {data_d, counter} is pushed if its phase is selected, then counter<=1.
    - Phase selected when edge_sel_i=00/11, or 01 with data_d=1, or 10 with data_d=0.
    - The counter restarts on every edge regardless of edge_sel_i.
  - Any state with meas_en_i=0: go to IDLE next cycle and clear the counter. FIFO contents and ovf_o are kept.
- Duration semantics: a phase sampled as the same level on N consecutive clocks yields duration N. Minimum recorded value is 1.
- Latency: for an edge sampled at cycle t, the record is written at the end of cycle t. It is visible on rd_data_o and fifo_empty_o falls at t+1.
- FIFO read:
  - Show-ahead: rd_data_o always presents the head entry.
  - rd_req_i with FIFO non-empty pops at the clock edge.
  - rd_req_i while empty is ignored; no state change and no error.
- FIFO write when full:
  - No simultaneous pop: the record is dropped, existing entries are untouched, and ovf_o<=1.
  - Simultaneous valid pop: both happen, level stays FIFO_DEPTH, no overflow.
- Push and pop when empty: the push happens, the pop is ignored, level becomes 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level_o is derived from an ADDR_W+1-bit occupancy count.
- ovf_o:
  - Set by a dropped push; cleared by clr_ovf_i.
  - If set and clear occur in the same cycle, set wins.
- irq_o: registered, equal to irq_en_i & (!fifo_empty_o | ovf_o), using next-state values. It deasserts in the cycle after the last pop.
- filter_type=00 upstream (filter disabled, data_i constant): no edges, so no records; the counter saturates.
- Asynchronous reset mid-operation clears everything, including FIFO pointers. Stored records are lost.

Decomposition:
- Package filter_meas_pkg:
  - state enum {IDLE, ARM, MEAS}.
  - edge_sel encodings SEL_BOTH=2'b00, SEL_HIGH=2'b01, SEL_LOW=2'b10.
  - Record field position constant LVL_BIT = CNT_W.
- Sub-module filter_meas_fifo: a generic synchronous show-ahead FIFO with push/pop/full/empty/level and a drop-on-full indication. The top block contains the edge detector, FSM, counter, overflow and IRQ logic.

Test Plan:
- Enable, then data_i goes 0→1, high 5 cycles, low 3 cycles, high again, edge_sel=00 → records {1,5} then {0,3}; first edge not recorded; fifo_level_o=2; irq_o=1 with irq_en_i=1.
- Same waveform with edge_sel=01 → only {1,5} recorded; edge_sel=10 → only {0,3}.
- Hold data_i high for 70000 cycles with CNT_W=16, then low → record {1,16'hFFFF} (saturation, no wrap).
- Generate 10 selected phases with no reads, FIFO_DEPTH=8 → level 8, fifo_full_o=1, ovf_o=1, first 8 records intact. clr_ovf_i → ovf_o=0. Repeat with a pop in the same cycle as a push while full → no overflow.
- rd_req_i while empty → no change. Drain all records → fifo_empty_o=1 and irq_o=0 one cycle later.
- Deassert meas_en_i mid-phase, reassert, toggle data_i → first post-enable edge not recorded and earlier FIFO contents preserved. Assert rstn_i=0 mid-run → all outputs return to reset values immediately.

Source files
------------

// File: rtl/filter_meas_pkg.sv
// Shared types and constants for the filtered-signal pulse measurement block.
package filter_meas_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meas_state_e;

  localparam logic [1:0] SEL_BOTH = 2'b00;
  localparam logic [1:0] SEL_HIGH = 2'b01;
  localparam logic [1:0] SEL_LOW  = 2'b10;

  localparam int unsigned CNT_W_DEF = 16;
  // Level bit sits just above the duration field of a record
  localparam int unsigned LVL_BIT   = CNT_W_DEF;

  // 2'b11 is an alias of SEL_BOTH
  function automatic logic phase_selected(input logic [1:0] sel, input logic lvl);
    case (sel)
      SEL_HIGH: phase_selected = lvl;
      SEL_LOW:  phase_selected = ~lvl;
      default:  phase_selected = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/filter_meas_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and drop-on-full indication.
module filter_meas_fifo #(
  parameter  int unsigned WIDTH = 17,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      level_o,
  output logic [AW:0]      level_nxt_o,
  output logic             drop_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             do_push, do_pop;

  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);
  assign level_o = count;
  assign rdata_o = empty_o ? '0 : mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop      = pop_i & ~empty_o;
  assign do_push     = push_i & (~full_o | do_pop);
  assign drop_o      = push_i & full_o & ~do_pop;
  assign level_nxt_o = count_nxt;

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + (AW+1)'(1);
    else if (!do_push && do_pop)
      count_nxt = count - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/filter_pulse_meas.sv
// Measures high/low phase durations of the filtered signal and queues {level, duration} records.
module filter_pulse_meas
  import filter_meas_pkg::*;
#(
  parameter  int unsigned CNT_W      = CNT_W_DEF,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              data_i,
  input  logic              meas_en_i,
  input  logic [1:0]        edge_sel_i,
  input  logic              irq_en_i,
  input  logic              rd_req_i,
  input  logic              clr_ovf_i,
  output logic [CNT_W:0]    rd_data_o,
  output logic              fifo_empty_o,
  output logic              fifo_full_o,
  output logic [ADDR_W:0]   fifo_level_o,
  output logic              ovf_o,
  output logic              irq_o
);

  meas_state_e      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             data_d, edge_det, push;
  logic             fifo_drop, ovf_nxt;
  logic [ADDR_W:0]  level_nxt;

  assign edge_det = data_i ^ data_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    if (!meas_en_i) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = ARM;
          cnt_nxt   = '0;
        end
        // Phase before the first edge is partial, so it only starts the count
        ARM: begin
          if (edge_det) begin
            cnt_nxt   = CNT_W'(1);
            state_nxt = MEAS;
          end
        end
        MEAS: begin
          if (edge_det) begin
            push    = phase_selected(edge_sel_i, data_d);
            cnt_nxt = CNT_W'(1);
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      cnt    <= '0;
      data_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_d <= data_i;
    end
  end

  filter_meas_fifo #(
    .WIDTH (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .push_i      (push),
    .pop_i       (rd_req_i),
    .wdata_i     ({data_d, cnt}),
    .rdata_o     (rd_data_o),
    .empty_o     (fifo_empty_o),
    .full_o      (fifo_full_o),
    .level_o     (fifo_level_o),
    .level_nxt_o (level_nxt),
    .drop_o      (fifo_drop)
  );

  // Set has priority over clear; irq uses next-state values so it tracks the FIFO without lag
  assign ovf_nxt = fifo_drop | (ovf_o & ~clr_ovf_i);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_o <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      ovf_o <= ovf_nxt;
      irq_o <= irq_en_i & ((level_nxt != '0) | ovf_nxt);
    end
  end

endmodule

// File: tb/tb_filter_pulse_meas.sv
// Directed self-checking bench for filter_pulse_meas.
module tb_filter_pulse_meas;

  localparam int unsigned CNT_W      = 16;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned ADDR_W     = 3;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic              data_i;
  logic              meas_en_i;
  logic [1:0]        edge_sel_i;
  logic              irq_en_i;
  logic              rd_req_i;
  logic              clr_ovf_i;
  logic [CNT_W:0]    rd_data_o;
  logic              fifo_empty_o;
  logic              fifo_full_o;
  logic [ADDR_W:0]   fifo_level_o;
  logic              ovf_o;
  logic              irq_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  filter_pulse_meas #(
    .CNT_W      (CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .data_i       (data_i),
    .meas_en_i    (meas_en_i),
    .edge_sel_i   (edge_sel_i),
    .irq_en_i     (irq_en_i),
    .rd_req_i     (rd_req_i),
    .clr_ovf_i    (clr_ovf_i),
    .rd_data_o    (rd_data_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_full_o  (fifo_full_o),
    .fifo_level_o (fifo_level_o),
    .ovf_o        (ovf_o),
    .irq_o        (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic phase(input logic lvl, input int unsigned n);
    data_i = lvl;
    step(n);
  endtask

  task automatic pop1();
    rd_req_i = 1'b1;
    step(1);
    rd_req_i = 1'b0;
  endtask

  // Re-arm, then: arm edge 0->1, high 5, low 3, rising edge
  task automatic wave();
    meas_en_i = 1'b0;
    step(1);
    meas_en_i = 1'b1;
    data_i    = 1'b0;
    step(2);
    phase(1'b1, 5);
    phase(1'b0, 3);
    phase(1'b1, 1);
  endtask

  initial begin
    logic [31:0] exp_rec;
    rstn_i = 1'b0; data_i = 1'b0; meas_en_i = 1'b0; edge_sel_i = 2'b00;
    irq_en_i = 1'b0; rd_req_i = 1'b0; clr_ovf_i = 1'b0;
    step(2);
    check("rst_empty", 32'(fifo_empty_o), 32'd1);
    check("rst_full",  32'(fifo_full_o),  32'd0);
    check("rst_level", 32'(fifo_level_o), 32'd0);
    check("rst_ovf",   32'(ovf_o),        32'd0);
    check("rst_irq",   32'(irq_o),        32'd0);
    check("rst_rdata", 32'(rd_data_o),    32'd0);
    rstn_i   = 1'b1;
    irq_en_i = 1'b1;

    // Both phases selected
    wave();
    check("both_level", 32'(fifo_level_o), 32'd2);
    check("both_head0", 32'(rd_data_o),    32'h10005);
    check("both_irq",   32'(irq_o),        32'd1);
    check("both_empty", 32'(fifo_empty_o), 32'd0);
    pop1();
    check("both_head1", 32'(rd_data_o),    32'h00003);
    check("both_lvl1",  32'(fifo_level_o), 32'd1);
    pop1();
    check("drain_empty", 32'(fifo_empty_o), 32'd1);
    check("drain_irq",   32'(irq_o),        32'd0);
    pop1();
    check("rd_empty_level", 32'(fifo_level_o), 32'd0);
    check("rd_empty_flag",  32'(fifo_empty_o), 32'd1);
    check("rd_empty_ovf",   32'(ovf_o),        32'd0);

    // High phases only, then low phases only
    edge_sel_i = 2'b01;
    wave();
    check("high_level", 32'(fifo_level_o), 32'd1);
    check("high_rec",   32'(rd_data_o),    32'h10005);
    pop1();
    edge_sel_i = 2'b10;
    wave();
    check("low_level", 32'(fifo_level_o), 32'd1);
    check("low_rec",   32'(rd_data_o),    32'h00003);
    pop1();
    check("low_drained", 32'(fifo_empty_o), 32'd1);

    // Long high phase saturates the counter
    edge_sel_i = 2'b00;
    meas_en_i  = 1'b0;
    step(1);
    meas_en_i  = 1'b1;
    data_i     = 1'b0;
    step(2);
    phase(1'b1, 70000);
    phase(1'b0, 1);
    check("sat_rec",   32'(rd_data_o),    32'h1FFFF);
    check("sat_level", 32'(fifo_level_o), 32'd1);
    pop1();

    // 10 phases into an 8-deep FIFO: phase i has level (i even) and length i+2
    meas_en_i = 1'b0;
    step(1);
    meas_en_i = 1'b1;
    data_i    = 1'b0;
    step(2);
    for (int unsigned i = 0; i <= 10; i++) phase(i % 2 == 0, i + 2);
    check("ovf_level", 32'(fifo_level_o), 32'd8);
    check("ovf_full",  32'(fifo_full_o),  32'd1);
    check("ovf_flag",  32'(ovf_o),        32'd1);
    check("ovf_irq",   32'(irq_o),        32'd1);
    check("ovf_head",  32'(rd_data_o),    32'h10002);
    clr_ovf_i = 1'b1;
    step(1);
    clr_ovf_i = 1'b0;
    check("clr_ovf",   32'(ovf_o),        32'd0);
    check("clr_level", 32'(fifo_level_o), 32'd8);

    // Falling edge ends the 13-cycle high phase while a pop frees a slot
    data_i   = 1'b0;
    rd_req_i = 1'b1;
    step(1);
    rd_req_i = 1'b0;
    check("pushpop_level", 32'(fifo_level_o), 32'd8);
    check("pushpop_ovf",   32'(ovf_o),        32'd0);
    check("pushpop_full",  32'(fifo_full_o),  32'd1);
    for (int unsigned i = 1; i <= 7; i++) begin
      exp_rec = ((i % 2 == 0) ? 32'h10000 : 32'h0) + i + 2;
      check("drain_rec", 32'(rd_data_o), exp_rec);
      pop1();
    end
    check("drain_last", 32'(rd_data_o), 32'h1000D);
    pop1();
    check("full_drain_empty", 32'(fifo_empty_o), 32'd1);
    check("full_drain_irq",   32'(irq_o),        32'd0);

    // Push and pop together while empty: low phase of 9 cycles is kept
    data_i   = 1'b1;
    rd_req_i = 1'b1;
    step(1);
    rd_req_i = 1'b0;
    check("pe_level", 32'(fifo_level_o), 32'd1);
    check("pe_rec",   32'(rd_data_o),    32'h00009);

    // Disable mid-phase; first edge after re-enable must not be recorded
    phase(1'b1, 2);
    meas_en_i = 1'b0;
    step(3);
    meas_en_i = 1'b1;
    step(1);
    phase(1'b0, 2);
    check("reen_level", 32'(fifo_level_o), 32'd1);
    check("reen_head",  32'(rd_data_o),    32'h00009);
    phase(1'b1, 1);
    check("reen_level2", 32'(fifo_level_o), 32'd2);

    // Asynchronous reset mid-cycle
    rstn_i = 1'b0;
    #1;
    check("arst_empty", 32'(fifo_empty_o), 32'd1);
    check("arst_full",  32'(fifo_full_o),  32'd0);
    check("arst_level", 32'(fifo_level_o), 32'd0);
    check("arst_ovf",   32'(ovf_o),        32'd0);
    check("arst_irq",   32'(irq_o),        32'd0);
    check("arst_rdata", 32'(rd_data_o),    32'd0);
    step(1);
    rstn_i = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
